// File: rtl/smp_timer_bank.sv
// SMP timer bank: N prescaled up-counters with programmable dividers, read-to-clear
// output counters, sticky overflow status and a masked, registered active-low IRQ.
module smp_timer_bank #(
  parameter int         N_TIMERS    = 3,
  parameter logic [7:0] FAST_MASK   = 8'b0000_0100,
  parameter int         SLOW_PERIOD = 384,
  parameter int         FAST_PERIOD = 48,
  parameter int         DIV_W       = 8,
  parameter int         OUT_W       = 4
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_ce,
  input  logic [5:0]          i_addr,
  input  logic                i_rd,
  input  logic                i_wr,
  input  logic [7:0]          i_wdata,
  output logic [7:0]          o_rdata,
  output logic                o_irq_n,
  output logic [N_TIMERS-1:0] o_tick
);

  localparam int ACC_W = 16;
  localparam logic [ACC_W-1:0] SLOW_P = ACC_W'(SLOW_PERIOD);
  localparam logic [ACC_W-1:0] FAST_P = ACC_W'(FAST_PERIOD);

  logic [1:0]          r_clk_speed;
  logic [1:0]          r_tm_speed;
  logic                r_ten;
  logic                r_tdis;
  logic [N_TIMERS-1:0] r_enable;
  logic [N_TIMERS-1:0] r_mask;
  logic [N_TIMERS-1:0] r_status;
  logic [DIV_W-1:0]    r_div [N_TIMERS];
  logic [DIV_W-1:0]    r_cnt [N_TIMERS];
  logic [OUT_W-1:0]    r_out [N_TIMERS];
  logic [ACC_W-1:0]    r_slow_acc;
  logic [ACC_W-1:0]    r_fast_acc;
  logic                r_irq_n;
  logic [N_TIMERS-1:0] r_tick;

  logic                w_wr;
  logic                w_rd;
  logic                w_run;
  logic [ACC_W-1:0]    w_step;
  logic [ACC_W-1:0]    w_slow_sum;
  logic [ACC_W-1:0]    w_fast_sum;
  logic                w_slow_tick;
  logic                w_fast_tick;
  logic                w_wr_ctrl;
  logic                w_wr_en;
  logic                w_wr_mask;
  logic                w_wr_stat;
  logic [N_TIMERS-1:0] w_clr;
  logic [N_TIMERS-1:0] w_en_rise;
  logic [N_TIMERS-1:0] w_count;
  logic [N_TIMERS-1:0] w_match;
  logic [N_TIMERS-1:0] w_inc;
  logic [N_TIMERS-1:0] w_ovf;
  logic [N_TIMERS-1:0] w_rd_out;
  logic [N_TIMERS-1:0] w_wr_div;
  logic [DIV_W-1:0]    w_cnt_nxt [N_TIMERS];

  assign w_wr  = i_ce & i_wr;
  assign w_rd  = i_ce & i_rd;
  assign w_run = r_ten & ~r_tdis;

  assign w_step      = (ACC_W'(1) << r_clk_speed) + (ACC_W'(2) << r_tm_speed);
  assign w_slow_sum  = r_slow_acc + w_step;
  assign w_fast_sum  = r_fast_acc + w_step;
  assign w_slow_tick = i_ce & (w_slow_sum >= SLOW_P);
  assign w_fast_tick = i_ce & (w_fast_sum >= FAST_P);

  assign w_wr_ctrl = w_wr & (i_addr == 6'h00);
  assign w_wr_en   = w_wr & (i_addr == 6'h01);
  assign w_wr_mask = w_wr & (i_addr == 6'h02);
  assign w_wr_stat = w_wr & (i_addr == 6'h03);
  assign w_clr     = w_wr_stat ? i_wdata[N_TIMERS-1:0] : '0;
  assign w_en_rise = w_wr_en ? (i_wdata[N_TIMERS-1:0] & ~r_enable) : '0;

  // An enable rising edge restarts the timer, so it suppresses a same-edge increment.
  always_comb begin
    w_count  = '0;
    w_match  = '0;
    w_inc    = '0;
    w_ovf    = '0;
    w_rd_out = '0;
    w_wr_div = '0;
    for (int i = 0; i < N_TIMERS; i++) begin
      w_cnt_nxt[i] = r_cnt[i] + 1'b1;
      w_count[i]   = (FAST_MASK[i] ? w_fast_tick : w_slow_tick) & r_enable[i] & w_run;
      w_match[i]   = w_count[i] & (w_cnt_nxt[i] == r_div[i]);
      w_inc[i]     = w_match[i] & ~w_en_rise[i];
      w_ovf[i]     = w_inc[i] & (&r_out[i]);
      w_rd_out[i]  = w_rd & (i_addr == (6'h20 + 6'(i)));
      w_wr_div[i]  = w_wr & (i_addr == (6'h10 + 6'(i)));
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_slow_acc <= '0;
      r_fast_acc <= '0;
    end else if (i_ce) begin
      r_slow_acc <= w_slow_tick ? (w_slow_sum - SLOW_P) : w_slow_sum;
      r_fast_acc <= w_fast_tick ? (w_fast_sum - FAST_P) : w_fast_sum;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_clk_speed <= '0;
      r_tm_speed  <= '0;
      r_ten       <= 1'b1;
      r_tdis      <= 1'b0;
      r_enable    <= '0;
      r_mask      <= '0;
      r_status    <= '0;
    end else begin
      if (w_wr_ctrl) begin
        r_clk_speed <= i_wdata[7:6];
        r_tm_speed  <= i_wdata[5:4];
        r_ten       <= i_wdata[3];
        r_tdis      <= i_wdata[0];
      end
      if (w_wr_en) r_enable <= i_wdata[N_TIMERS-1:0];
      if (w_wr_mask) r_mask <= i_wdata[N_TIMERS-1:0];
      // A fresh overflow beats a same-edge write-1-to-clear.
      r_status <= w_ovf | (r_status & ~w_clr);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < N_TIMERS; i++) begin
        r_div[i] <= '1;
        r_cnt[i] <= '0;
        r_out[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_TIMERS; i++) begin
        if (w_wr_div[i]) r_div[i] <= i_wdata[DIV_W-1:0];
        if (w_en_rise[i]) begin
          r_cnt[i] <= '0;
          r_out[i] <= '0;
        end else begin
          if (w_count[i]) r_cnt[i] <= w_match[i] ? '0 : w_cnt_nxt[i];
          // Read-to-clear keeps a same-edge increment instead of dropping it.
          if (w_rd_out[i]) r_out[i] <= OUT_W'(w_inc[i]);
          else if (w_inc[i]) r_out[i] <= r_out[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_irq_n <= 1'b1;
      r_tick  <= '0;
    end else begin
      r_irq_n <= ~|(r_status & r_mask);
      r_tick  <= w_inc;
    end
  end

  assign o_irq_n = r_irq_n;
  assign o_tick  = r_tick;

  always_comb begin
    o_rdata = '0;
    case (i_addr)
      6'h00:   o_rdata = {r_clk_speed, r_tm_speed, r_ten, 2'b00, r_tdis};
      6'h01:   o_rdata = 8'(r_enable);
      6'h02:   o_rdata = 8'(r_mask);
      6'h03:   o_rdata = 8'(r_status);
      default: o_rdata = '0;
    endcase
    for (int i = 0; i < N_TIMERS; i++) begin
      if (i_addr == (6'h10 + 6'(i))) o_rdata = 8'(r_div[i]);
      if (i_addr == (6'h20 + 6'(i))) o_rdata = 8'(r_out[i]);
    end
  end

endmodule
